graph_fetch_multi: RTL

//  Next-generation neighbour fetcher for graph traversal. Given a vertex record address, walks the

---
 rtl/graph_fetch_multi.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/graph_fetch_multi.sv
// Graph neighbour fetcher: walks a zero-terminated neighbour list, filters neighbours by
// visited state and queues each unvisited neighbour pointer plus its position words.

module graph_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq,
  input  logic [W-1:0]  enq_data,
  input  logic          deq,
  output logic [W-1:0]  head,
  output logic          not_empty,
  output logic          full,
  output logic [CW-1:0] used
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  slots [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_enq, do_deq;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = (used != '0);
  assign full      = (used == CW'(DEPTH));
  assign do_deq    = deq && not_empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign do_enq    = enq && (!full || do_deq);
  assign head      = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_enq) wr_ptr <= bump(wr_ptr);
      if (do_deq) rd_ptr <= bump(rd_ptr);
      if (do_enq && !do_deq)      used <= used + 1'b1;
      else if (do_deq && !do_enq) used <= used - 1'b1;
    end
  end

  always_ff @(posedge clk) if (do_enq) slots[wr_ptr] <= enq_data;
endmodule

module graph_fetch_multi #(
  parameter int DIM          = 2,
  parameter int DATA_W       = 32,
  parameter int NEIGH_DEPTH  = 4,
  parameter int POS_DEPTH    = 8,
  parameter int MAX_DEG      = 16,
  parameter int MARK_VISITED = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] v_addr_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [7:0]        neigh_count_out,
  input  logic              neigh_deq_in,
  output logic [DATA_W-1:0] neigh_data_out,
  output logic              neigh_valid_out,
  output logic              neigh_full_out,
  input  logic              pos_deq_in,
  output logic [DATA_W-1:0] pos_data_out,
  output logic              pos_valid_out,
  output logic              pos_full_out,
  output logic [DATA_W-1:0] mem_req_addr_out,
  output logic              mem_req_valid_out,
  input  logic              mem_req_ready_in,
  input  logic              mem_resp_valid_in,
  input  logic [DATA_W-1:0] mem_resp_data_in,
  output logic [DATA_W-1:0] vis_req_id_out,
  output logic              vis_req_mark_out,
  output logic              vis_req_valid_out,
  input  logic              vis_req_ready_in,
  input  logic              vis_resp_valid_in,
  input  logic              vis_resp_hit_in
);
  localparam int NCW = $clog2(NEIGH_DEPTH + 1);
  localparam int PCW = $clog2(POS_DEPTH + 1);

  typedef enum logic [3:0] {
    IDLE, LIST_RD, LIST_WT, ID_RD, ID_WT, VIS_RQ, VIS_WT, POS_RD, POS_WT, PUSH, DONE
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] ptr, nbr, vid;
  logic [15:0]       slot;
  logic [7:0]        k, count;
  logic [NCW-1:0]    n_used;
  logic [PCW-1:0]    p_used;
  logic              room, cap, mem_ack, mem_rx, vis_ack, vis_rx, pos_enq, neigh_enq;

  // a list read is only issued when a whole neighbour (pointer + DIM words) fits
  assign room = (32'(n_used) < NEIGH_DEPTH) && (32'(p_used) + DIM <= POS_DEPTH);
  assign cap  = (MAX_DEG != 0) && (slot == 16'(MAX_DEG));

  always_comb begin
    mem_req_valid_out = 1'b0;
    mem_req_addr_out  = '0;
    case (state)
      LIST_RD: begin mem_req_valid_out = room; mem_req_addr_out = ptr; end
      ID_RD:   begin mem_req_valid_out = 1'b1; mem_req_addr_out = nbr; end
      POS_RD:  begin mem_req_valid_out = 1'b1; mem_req_addr_out = nbr + DATA_W'(k) + 1'b1; end
      default: ;
    endcase
  end

  // responses may arrive in the same cycle the request is accepted
  assign mem_ack = mem_req_valid_out && mem_req_ready_in;
  assign mem_rx  = mem_resp_valid_in && (mem_ack || (state inside {LIST_WT, ID_WT, POS_WT}));

  assign vis_req_valid_out = (state == VIS_RQ);
  assign vis_req_id_out    = vid;
  assign vis_req_mark_out  = (MARK_VISITED != 0);
  assign vis_ack           = vis_req_valid_out && vis_req_ready_in;
  assign vis_rx            = vis_resp_valid_in && (vis_ack || state == VIS_WT);

  assign pos_enq   = mem_rx && (state inside {POS_RD, POS_WT});
  assign neigh_enq = (state == PUSH);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (valid_in) state_nx = LIST_RD;
      LIST_RD, LIST_WT:
        if (mem_rx)       state_nx = (mem_resp_data_in == '0) ? DONE : ID_RD;
        else if (mem_ack) state_nx = LIST_WT;
      ID_RD, ID_WT:
        if (mem_rx)       state_nx = VIS_RQ;
        else if (mem_ack) state_nx = ID_WT;
      VIS_RQ, VIS_WT:
        if (vis_rx)       state_nx = !vis_resp_hit_in ? POS_RD : (cap ? DONE : LIST_RD);
        else if (vis_ack) state_nx = VIS_WT;
      POS_RD, POS_WT:
        if (mem_rx)       state_nx = (k == 8'(DIM - 1)) ? PUSH : POS_RD;
        else if (mem_ack) state_nx = POS_WT;
      PUSH:    state_nx = cap ? DONE : LIST_RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      ptr   <= '0;
      nbr   <= '0;
      vid   <= '0;
      slot  <= '0;
      k     <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (valid_in) begin
          ptr   <= v_addr_in + DATA_W'(DIM + 1);
          slot  <= '0;
          count <= '0;
        end
        LIST_RD, LIST_WT: if (mem_rx && mem_resp_data_in != '0) begin
          nbr  <= mem_resp_data_in;
          ptr  <= ptr + 1'b1;
          slot <= slot + 1'b1;
        end
        ID_RD, ID_WT:   if (mem_rx) vid <= mem_resp_data_in;
        VIS_RQ, VIS_WT: if (vis_rx) k <= '0;
        POS_RD, POS_WT: if (mem_rx) k <= k + 1'b1;
        PUSH:           if (count != 8'hFF) count <= count + 1'b1;
        default: ;
      endcase
    end
  end

  assign ready_out       = (state == IDLE);
  assign busy_out        = (state != IDLE);
  assign done_out        = (state == DONE);
  assign neigh_count_out = count;

  graph_fetch_fifo #(.W(DATA_W), .DEPTH(NEIGH_DEPTH)) u_neigh (
    .clk(clk_in), .rst_n(rst_n_in), .enq(neigh_enq), .enq_data(nbr), .deq(neigh_deq_in),
    .head(neigh_data_out), .not_empty(neigh_valid_out), .full(neigh_full_out), .used(n_used)
  );

  graph_fetch_fifo #(.W(DATA_W), .DEPTH(POS_DEPTH)) u_pos (
    .clk(clk_in), .rst_n(rst_n_in), .enq(pos_enq), .enq_data(mem_resp_data_in), .deq(pos_deq_in),
    .head(pos_data_out), .not_empty(pos_valid_out), .full(pos_full_out), .used(p_used)
  );
endmodule
